// File: rtl/drone_pkg.sv
// Shared types and default throttle-ramp constants for the motor ramp controller.
package drone_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SPINUP  = 2'd1,
        HOVER   = 2'd2,
        DESCEND = 2'd3
    } ramp_state_t;

    localparam int THR_W        = 8;
    localparam int THR_HOVER    = 128;
    localparam int THR_IDLE     = 16;
    localparam int THR_STEP     = 4;
    localparam int THR_TICK_DIV = 10;

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// Request/status bundle between the flight-mode FSM (master) and the ramp controller (slave).
interface motor_ramp_ctrl_if
    import drone_pkg::*;
#(
    parameter int W = THR_W
);
    logic         takeoff;
    logic         landing;
    logic [W-1:0] throttle;
    logic         armed;
    logic         at_hover;
    logic         landed;

    modport master (
        output takeoff,
        output landing,
        input  throttle,
        input  armed,
        input  at_hover,
        input  landed
    );

    modport slave (
        input  takeoff,
        input  landing,
        output throttle,
        output armed,
        output at_hover,
        output landed
    );
endinterface

// File: rtl/ramp_tick_gen.sv
// Ramp tick divider: counts 0..TICK_DIV-1 while enabled, tick on the terminal count.
module ramp_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/motor_ramp_ctrl.sv
// Rate-limited throttle sequencer: spin-up to hover on takeoff, ramp to zero on landing.
//   state   | meaning
//   IDLE    | motors off, throttle 0, waiting for takeoff
//   SPINUP  | ramping throttle up by STEP per tick towards HOVER_LEVEL
//   HOVER   | throttle held at HOVER_LEVEL
//   DESCEND | ramping throttle down by STEP per tick towards 0
module motor_ramp_ctrl
    import drone_pkg::*;
#(
    parameter int W           = THR_W,
    parameter int HOVER_LEVEL = THR_HOVER,
    parameter int IDLE_LEVEL  = THR_IDLE,
    parameter int STEP        = THR_STEP,
    parameter int TICK_DIV    = THR_TICK_DIV
) (
    input  logic              clk,
    input  logic              reset,
    motor_ramp_ctrl_if.slave  ctrl
);
    localparam logic [W:0]   STEP_X  = (W+1)'(STEP);
    localparam logic [W:0]   HOVER_X = (W+1)'(HOVER_LEVEL);
    localparam logic [W-1:0] HOVER_V = W'(HOVER_LEVEL);
    localparam logic [W-1:0] IDLE_V  = W'(IDLE_LEVEL);

    ramp_state_t  state_q, state_d;
    logic [W-1:0] throttle_q, throttle_d;
    logic         armed_q, armed_d;
    logic         at_hover_q, at_hover_d;
    logic         landed_q, landed_d;

    logic         tick;
    logic         tick_en;
    logic         tick_clr;
    logic [W:0]   thr_x;
    logic [W:0]   sum_x;
    logic [W-1:0] thr_up;
    logic [W-1:0] thr_dn;
    logic         launch;

    assign launch = ctrl.takeoff && !ctrl.landing;

    // Widened arithmetic so the up-ramp cannot wrap and the down-ramp cannot underflow.
    assign thr_x  = {1'b0, throttle_q};
    assign sum_x  = thr_x + STEP_X;
    assign thr_up = (sum_x >= HOVER_X) ? HOVER_V : W'(sum_x);
    assign thr_dn = (thr_x > STEP_X) ? W'(thr_x - STEP_X) : '0;

    always_comb begin
        state_d    = state_q;
        throttle_d = throttle_q;
        case (state_q)
            IDLE: begin
                throttle_d = '0;
                if (launch) begin
                    state_d    = SPINUP;
                    throttle_d = IDLE_V;
                end
            end
            SPINUP: begin
                if (ctrl.landing) begin
                    state_d = DESCEND;
                end else if (tick) begin
                    throttle_d = thr_up;
                    if (thr_up == HOVER_V) state_d = HOVER;
                end
            end
            HOVER: begin
                throttle_d = HOVER_V;
                if (ctrl.landing) state_d = DESCEND;
            end
            DESCEND: begin
                if (launch) begin
                    state_d    = SPINUP;
                    throttle_d = (throttle_q < IDLE_V) ? IDLE_V : throttle_q;
                end else if (tick) begin
                    throttle_d = thr_dn;
                    if (thr_dn == '0) state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                throttle_d = '0;
            end
        endcase
        armed_d    = (state_d != IDLE);
        at_hover_d = (state_d == HOVER);
        landed_d   = (state_q == DESCEND) && (state_d == IDLE);
    end

    assign tick_en  = (state_q == SPINUP) || (state_q == DESCEND);
    assign tick_clr = (state_d != state_q) || !tick_en;

    ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            throttle_q <= '0;
            armed_q    <= 1'b0;
            at_hover_q <= 1'b0;
            landed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            throttle_q <= throttle_d;
            armed_q    <= armed_d;
            at_hover_q <= at_hover_d;
            landed_q   <= landed_d;
        end
    end

    assign ctrl.throttle = throttle_q;
    assign ctrl.armed    = armed_q;
    assign ctrl.at_hover = at_hover_q;
    assign ctrl.landed   = landed_q;
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: default-parameter instance plus a TICK_DIV=1, STEP=5 instance.
module tb_motor_ramp_ctrl;
    logic clk;
    logic reset;
    int   tests;
    int   failed;
    int   land_a;
    int   land_b;
    int   exp_dn [6];

    motor_ramp_ctrl_if #(.W(8)) bus_a ();
    motor_ramp_ctrl_if #(.W(8)) bus_b ();

    motor_ramp_ctrl u_dut_a (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus_a)
    );

    motor_ramp_ctrl #(
        .W           (8),
        .HOVER_LEVEL (30),
        .IDLE_LEVEL  (16),
        .STEP        (5),
        .TICK_DIV    (1)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts landed pulses, one per high cycle.
    always @(negedge clk) begin
        if (bus_a.landed === 1'b1) land_a++;
        if (bus_b.landed === 1'b1) land_b++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        land_a = 0;
        land_b = 0;
        reset  = 1'b0;
        bus_a.takeoff = 1'b0;
        bus_a.landing = 1'b0;
        bus_b.takeoff = 1'b0;
        bus_b.landing = 1'b0;
        #12;
        reset = 1'b1;
        step(1);
        chk("rst_thr_a", 32'(bus_a.throttle), 0);
        chk("rst_armed_a", 32'(bus_a.armed), 0);
        chk("rst_hover_a", 32'(bus_a.at_hover), 0);
        chk("rst_landed_a", 32'(bus_a.landed), 0);
        chk("rst_thr_b", 32'(bus_b.throttle), 0);
        chk("rst_armed_b", 32'(bus_b.armed), 0);

        // 1: reset in the middle of a ramp
        bus_a.takeoff = 1'b1;
        step(1);
        step(35);
        chk("pre_rst_thr", 32'(bus_a.throttle), 28);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_thr", 32'(bus_a.throttle), 0);
        chk("async_rst_armed", 32'(bus_a.armed), 0);
        bus_a.takeoff = 1'b0;
        #1;
        reset = 1'b1;
        step(1);
        land_a = 0;
        step(50);
        chk("post_rst_thr", 32'(bus_a.throttle), 0);
        chk("post_rst_armed", 32'(bus_a.armed), 0);
        chk("post_rst_landed", 32'(land_a), 0);

        // 2: full spin-up
        bus_a.takeoff = 1'b1;
        step(1);
        chk("arm_thr", 32'(bus_a.throttle), 16);
        chk("arm_armed", 32'(bus_a.armed), 1);
        step(9);
        chk("pre_tick1", 32'(bus_a.throttle), 16);
        step(1);
        chk("tick1", 32'(bus_a.throttle), 20);
        step(269);
        chk("pre_hover_thr", 32'(bus_a.throttle), 124);
        chk("pre_hover_flag", 32'(bus_a.at_hover), 0);
        step(1);
        chk("hover_thr", 32'(bus_a.throttle), 128);
        chk("hover_flag", 32'(bus_a.at_hover), 1);
        bus_a.takeoff = 1'b0;
        step(5);
        bus_a.takeoff = 1'b1;
        step(5);
        bus_a.takeoff = 1'b0;
        step(1);
        chk("hover_hold_thr", 32'(bus_a.throttle), 128);
        chk("hover_hold_flag", 32'(bus_a.at_hover), 1);

        // 3: landing from hover
        land_a = 0;
        bus_a.landing = 1'b1;
        step(1);
        chk("land_hover_drop", 32'(bus_a.at_hover), 0);
        chk("land_armed", 32'(bus_a.armed), 1);
        step(9);
        chk("land_pre_tick", 32'(bus_a.throttle), 128);
        step(1);
        chk("land_tick1", 32'(bus_a.throttle), 124);
        step(309);
        chk("land_pre_zero", 32'(bus_a.throttle), 4);
        chk("land_pre_zero_armed", 32'(bus_a.armed), 1);
        step(1);
        chk("land_zero_thr", 32'(bus_a.throttle), 0);
        chk("land_zero_armed", 32'(bus_a.armed), 0);
        chk("landed_pulse", 32'(bus_a.landed), 1);
        step(1);
        chk("landed_end", 32'(bus_a.landed), 0);
        step(5);
        chk("landed_count", 32'(land_a), 1);
        bus_a.landing = 1'b0;

        // 4: simultaneous requests
        bus_a.takeoff = 1'b1;
        bus_a.landing = 1'b1;
        step(20);
        chk("both_idle_thr", 32'(bus_a.throttle), 0);
        chk("both_idle_armed", 32'(bus_a.armed), 0);
        bus_a.landing = 1'b0;
        step(1);
        chk("rearm_thr", 32'(bus_a.throttle), 16);
        step(280);
        chk("rehover_flag", 32'(bus_a.at_hover), 1);
        bus_a.landing = 1'b1;
        step(1);
        chk("both_hover_flag", 32'(bus_a.at_hover), 0);
        step(10);
        chk("both_hover_desc", 32'(bus_a.throttle), 124);
        step(310);
        chk("both_land_armed", 32'(bus_a.armed), 0);
        bus_a.takeoff = 1'b0;
        bus_a.landing = 1'b0;
        step(2);

        // 5: abort and re-launch
        bus_a.takeoff = 1'b1;
        step(1);
        step(60);
        chk("abort_at40", 32'(bus_a.throttle), 40);
        bus_a.landing = 1'b1;
        step(1);
        chk("abort_edge", 32'(bus_a.throttle), 40);
        step(10);
        chk("abort_36", 32'(bus_a.throttle), 36);
        step(10);
        chk("abort_32", 32'(bus_a.throttle), 32);
        step(60);
        chk("abort_8", 32'(bus_a.throttle), 8);
        chk("abort_8_armed", 32'(bus_a.armed), 1);
        bus_a.landing = 1'b0;
        step(1);
        chk("relaunch_clamp", 32'(bus_a.throttle), 16);
        chk("relaunch_armed", 32'(bus_a.armed), 1);
        step(10);
        chk("relaunch_tick", 32'(bus_a.throttle), 20);

        // 6: non-multiple step, TICK_DIV=1
        bus_b.takeoff = 1'b1;
        step(1);
        chk("b_up_16", 32'(bus_b.throttle), 16);
        step(1);
        chk("b_up_21", 32'(bus_b.throttle), 21);
        step(1);
        chk("b_up_26", 32'(bus_b.throttle), 26);
        step(1);
        chk("b_up_30", 32'(bus_b.throttle), 30);
        chk("b_hover", 32'(bus_b.at_hover), 1);
        step(1);
        chk("b_hold_30", 32'(bus_b.throttle), 30);
        bus_b.takeoff = 1'b0;
        bus_b.landing = 1'b1;
        step(1);
        chk("b_desc_edge", 32'(bus_b.throttle), 30);
        exp_dn = '{25, 20, 15, 10, 5, 0};
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("b_dn_%0d", i), 32'(bus_b.throttle), 32'(exp_dn[i]));
        end
        chk("b_dn_armed", 32'(bus_b.armed), 0);
        chk("b_landed", 32'(bus_b.landed), 1);
        step(1);
        chk("b_stay_zero", 32'(bus_b.throttle), 0);
        chk("b_landed_count", 32'(land_b), 1);
        bus_b.landing = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
